// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//
// Moore state machine that walks every instruction through the phases
// FETCH -> DECODE -> EXECUTE -> (MEM_WAIT | IO_WAIT | HALT) -> WRITEBACK.
// It sits between the combinational control core and the datapath and turns
// the core's "this instruction wants to ..." levels into single-cycle commit
// strobes. Register-bank writes, memory write strobes, flag commits and PC
// advance therefore each happen exactly once per instruction.
//
// Parameters
//   FETCH_WAIT  cycles spent in FETCH before the IR loads      (1..15)
//   MEM_WAIT    cycles spent in MEM_WAIT for loads and stores  (1..15)
//   COUNT_W     width of the retired-instruction counter
//
// Ports
//   clock             system clock, rising edge
//   reset             asynchronous, active-low reset
//   core_enable       0 marks a HALT instruction
//   mem_access        instruction is a load or store
//   is_store          memory access is a write
//   wait_input        instruction reads the switches (INSW)
//   rb_request        instruction writes the register bank
//   flag_request      instruction updates the special registers
//   input_ready       operator confirmed input (pulse)
//   resume            leave HALT (pulse)
//   ir_load           latch the instruction register
//   rb_write_enable   commit the register-bank write
//   mem_write_strobe  one-cycle memory write enable
//   flags_commit      commit the special-register update
//   pc_enable         advance the PC
//   halted            high while parked in HALT
//   phase             current state encoding (debug / LEDs)
//   retired_count     number of completed instructions (wraps)
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int FETCH_WAIT = 1,
    parameter int MEM_WAIT   = 2,
    parameter int COUNT_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               core_enable,
    input  logic               mem_access,
    input  logic               is_store,
    input  logic               wait_input,
    input  logic               rb_request,
    input  logic               flag_request,
    input  logic               input_ready,
    input  logic               resume,
    output logic               ir_load,
    output logic               rb_write_enable,
    output logic               mem_write_strobe,
    output logic               flags_commit,
    output logic               pc_enable,
    output logic               halted,
    output logic [2:0]         phase,
    output logic [COUNT_W-1:0] retired_count
);

    // Wait counts of zero would make FETCH/MEM_WAIT unreachable-to-exit
    // ranges for the 4-bit counter, so reject them at elaboration.
    generate
        if (FETCH_WAIT < 1 || FETCH_WAIT > 15) begin : g_bad_fetch_wait
            $error("multicycle_sequencer: FETCH_WAIT must be in 1..15");
        end
        if (MEM_WAIT < 1 || MEM_WAIT > 15) begin : g_bad_mem_wait
            $error("multicycle_sequencer: MEM_WAIT must be in 1..15");
        end
        if (COUNT_W < 1) begin : g_bad_count_w
            $error("multicycle_sequencer: COUNT_W must be at least 1");
        end
    endgenerate

    // The encodings double as the externally visible phase value.
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM_WAIT  = 3'd3,
        ST_IO_WAIT   = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    // Snapshot of the control core's request lines taken at the end of
    // DECODE; everything after DECODE works from this copy only.
    typedef struct packed {
        logic enable;
        logic mem;
        logic store;
        logic wait_in;
        logic rb;
        logic flag;
    } req_t;

    localparam logic [3:0] FETCH_LAST = 4'(FETCH_WAIT - 1);
    localparam logic [3:0] MEM_LAST   = 4'(MEM_WAIT - 1);

    state_t               state_q,    state_d;
    logic   [3:0]         wait_cnt_q, wait_cnt_d;
    req_t                 req_q,      req_d;
    logic   [COUNT_W-1:0] retired_q,  retired_d;

    logic fetch_last;
    logic mem_last;

    // Final cycle of the two counted wait phases.
    assign fetch_last = (state_q == ST_FETCH)    && (wait_cnt_q == FETCH_LAST);
    assign mem_last   = (state_q == ST_MEM_WAIT) && (wait_cnt_q == MEM_LAST);

    // State, counter, request snapshot and retired counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
            req_q      <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            req_q      <= req_d;
            retired_q  <= retired_d;
        end
    end

    // Next-state logic. Datapath inputs are consulted only in DECODE (the
    // request snapshot), IO_WAIT (input_ready) and HALT (resume), so pulses
    // arriving in any other phase are dropped rather than remembered.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_d      = req_q;
        retired_d  = retired_q;

        case (state_q)
            ST_FETCH: begin
                if (fetch_last) begin
                    state_d    = ST_DECODE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end

            ST_DECODE: begin
                req_d.enable  = core_enable;
                req_d.mem     = mem_access;
                req_d.store   = is_store;
                req_d.wait_in = wait_input;
                req_d.rb      = rb_request;
                req_d.flag    = flag_request;
                state_d       = ST_EXECUTE;
            end

            // HALT outranks INSW, which outranks a memory access.
            ST_EXECUTE: begin
                if (!req_q.enable) begin
                    state_d = ST_HALT;
                end else if (req_q.wait_in) begin
                    state_d = ST_IO_WAIT;
                end else if (req_q.mem) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end

            ST_MEM_WAIT: begin
                if (mem_last) begin
                    state_d    = ST_WRITEBACK;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end

            ST_IO_WAIT: begin
                if (input_ready) begin
                    state_d = ST_WRITEBACK;
                end
            end

            // WRITEBACK retires the instruction, including a resumed HALT.
            ST_WRITEBACK: begin
                retired_d = retired_q + COUNT_W'(1);
                state_d   = ST_FETCH;
            end

            ST_HALT: begin
                if (resume) begin
                    state_d = ST_WRITEBACK;
                end
            end

            default: begin
                state_d    = ST_FETCH;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Moore outputs: decoded from registered state, counter and snapshot
    // only, so they cannot glitch with the datapath inputs. ir_load is
    // additionally qualified by reset because with FETCH_WAIT=1 the reset
    // state is itself the last FETCH cycle, and nothing may strobe while
    // reset is held.
    always_comb begin
        ir_load          = fetch_last && reset;
        rb_write_enable  = 1'b0;
        mem_write_strobe = 1'b0;
        flags_commit     = 1'b0;
        pc_enable        = 1'b0;
        halted           = 1'b0;

        case (state_q)
            ST_MEM_WAIT: begin
                mem_write_strobe = mem_last && req_q.store;
            end
            ST_WRITEBACK: begin
                rb_write_enable = req_q.rb;
                flags_commit    = req_q.flag;
                pc_enable       = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign phase         = state_q;
    assign retired_count = retired_q;

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Moore FSM that sequences each instruction through fetch, decode, execute, memory wait, I/O wait, writeback and halt phases.
- Sits between the combinational control core and the datapath.
- Gates register-bank writes, memory write strobes, flag commits and PC advance so that each occurs exactly once per instruction.
- Provides wait states for slow memory, stalls INSW until the operator confirms input, and parks the core on HALT until resumed.

Parameters:
- FETCH_WAIT, 1, cycles spent in FETCH before the instruction register loads (legal range 1..15)
- MEM_WAIT, 2, cycles spent in MEM_WAIT for loads and stores (legal range 1..15)
- COUNT_W, 32, width of the retired-instruction counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- core_enable  in  1  control-core enable; 0 marks a HALT instruction
- mem_access  in  1  current instruction is a load or store
- is_store  in  1  current memory access is a write
- wait_input  in  1  current instruction reads the switches (INSW)
- rb_request  in  1  current instruction writes the register bank (control core RB select is nonzero)
- flag_request  in  1  current instruction updates special registers (update mode is nonzero)
- input_ready  in  1  single-cycle pulse when the operator confirms input
- resume  in  1  single-cycle pulse to leave HALT
- ir_load  out  1  latch the instruction register
- rb_write_enable  out  1  commit the register-bank write
- mem_write_strobe  out  1  one-cycle memory write enable
- flags_commit  out  1  commit the special-register update
- pc_enable  out  1  advance the PC
- halted  out  1  high while in HALT
- phase  out  3  current state encoding, for debug and LEDs
- retired_count  out  COUNT_W  number of completed instructions

Behaviour:
- State encoding (phase): FETCH=0, DECODE=1, EXECUTE=2, MEM_WAIT=3, IO_WAIT=4, WRITEBACK=5, HALT=6.
- Reset (asynchronous, while reset=0):
  - state=FETCH; wait counter=0; request latches=0; retired_count=0.
  - All outputs 0; phase=0.
  - Reset asserted mid-instruction abandons the instruction with no strobes issued.
- FETCH: holds for FETCH_WAIT cycles using a 4-bit counter.
  - ir_load=1 in the last FETCH cycle only.
  - Next state DECODE; counter clears on exit.
- DECODE: 1 cycle.
  - At the end of the cycle, latch core_enable, mem_access, is_store, wait_input, rb_request and flag_request into request registers.
  - From this point, datapath inputs are ignored until the next DECODE.
- EXECUTE: 1 cycle. Next state by priority, using the latched bits:
  - core_enable=0 -> HALT
  - else wait_input=1 -> IO_WAIT
  - else mem_access=1 -> MEM_WAIT
  - else -> WRITEBACK
- MEM_WAIT: holds for MEM_WAIT cycles.
  - mem_write_strobe=1 in the last cycle only, and only if is_store is latched.
  - Next state WRITEBACK.
- IO_WAIT: stays until input_ready=1 is sampled, then WRITEBACK.
  - There is no timeout.
  - input_ready pulses outside IO_WAIT are ignored and not remembered.
- WRITEBACK: 1 cycle, all strobes issued together in this cycle:
  - rb_write_enable = latched rb_request
  - flags_commit = latched flag_request
  - pc_enable = 1
  - retired_count increments, wrapping modulo 2^COUNT_W
  - Next state FETCH.
  - A store therefore asserts rb_write_enable only if rb_request was latched.
- HALT: halted=1; all other strobes 0.
  - Stays until resume=1 is sampled, then WRITEBACK, so the HALT retires and the PC moves past it.
  - resume outside HALT is ignored.
- Outputs are pure functions of the registered state, counter and latched requests. They are glitch-free relative to datapath inputs.
- Simultaneous events:
  - input_ready and resume in the same cycle: only the pulse relevant to the current state acts.
  - HALT takes priority over INSW and memory access when both are flagged.
- Cycle counts with FETCH_WAIT=1, MEM_WAIT=2:
  - ALU instruction: 4 cycles
  - load/store: 6 cycles
  - INSW: 4 cycles + wait for input_ready
  - HALT: 4 cycles + wait for resume
- Illegal parameter values (0 wait cycles) are not supported; an elaboration-time check flags them.

Test Plan:
- Release reset, hold core_enable=1 and all other requests 0 with rb_request=1 -> phase 0,1,2,5 repeating; ir_load in cycle 1, rb_write_enable and pc_enable in cycle 4; retired_count=3 after 12 cycles.
- Store (mem_access=1, is_store=1, rb_request=0) -> phases 0,1,2,3,3,5; mem_write_strobe high only in the second MEM_WAIT cycle; rb_write_enable stays 0; pc_enable pulses once.
- INSW (wait_input=1, rb_request=1), input_ready pulsed 10 cycles after entering IO_WAIT, plus an extra input_ready pulse during FETCH -> IO_WAIT lasts 10 cycles, then WRITEBACK with rb_write_enable=1; the FETCH pulse has no effect.
- HALT (core_enable=0, flag_request=1, mem_access=1) -> HALT entered from EXECUTE with halted=1 and no mem strobe; an early resume before the halt is ignored; resume in HALT -> WRITEBACK with flags_commit=1 and pc_enable=1.
- Drop reset during MEM_WAIT of a store -> outputs 0 immediately, no mem_write_strobe, retired_count=0; after release, the sequence restarts at FETCH.
- Set COUNT_W=4 and run 17 ALU instructions -> retired_count wraps to 1.
